// File: rtl/flu_wb_scheduler.sv
// FLU writeback scheduler: fast-vs-multiplier arbitration, result FIFO, credits.
// Optional starvation guard enabled by defining FLU_WB_STARVE_GUARD_EN.
module flu_wb_scheduler #(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       fast_valid_i,
  input  logic [TRANS_ID_BITS-1:0]   fast_trans_id_i,
  input  logic [XLEN-1:0]            fast_result_i,
  output logic                       fast_ready_o,
  input  logic                       mul_issue_i,
  output logic                       mul_issue_ready_o,
  input  logic                       mul_valid_i,
  input  logic [TRANS_ID_BITS-1:0]   mul_trans_id_i,
  input  logic [XLEN-1:0]            mul_result_i,
  output logic                       wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [XLEN-1:0]            wb_result_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]            credits_q, credits_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [TRANS_ID_BITS-1:0] id_mem_q [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem_d [DEPTH];
  logic [XLEN-1:0]          res_mem_q [DEPTH];
  logic [XLEN-1:0]          res_mem_d [DEPTH];
  logic                     wb_valid_q, wb_valid_d;
  logic [TRANS_ID_BITS-1:0] wb_id_q, wb_id_d;
  logic [XLEN-1:0]          wb_res_q, wb_res_d;

  logic fifo_empty;
  logic sel_fast, sel_head, sel_byp;
  logic push, pop, issue_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_empty        = (cnt_q == '0);
  assign sel_fast          = fast_valid_i;
  assign sel_head          = !fast_valid_i && !fifo_empty;
  assign sel_byp           = !fast_valid_i && fifo_empty && mul_valid_i;
  assign push              = mul_valid_i && !sel_byp;
  assign pop               = sel_head;
  assign mul_issue_ready_o = (credits_q < CW'(DEPTH));
  assign issue_ok          = mul_issue_i && mul_issue_ready_o;
  assign occupancy_o       = cnt_q;
  assign wb_valid_o        = wb_valid_q;
  assign wb_trans_id_o     = wb_id_q;
  assign wb_result_o       = wb_res_q;

  // Arbitration, FIFO push/pop and credit bookkeeping; flush wipes it all.
  always_comb begin
    credits_d  = credits_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    id_mem_d   = id_mem_q;
    res_mem_d  = res_mem_q;
    wb_valid_d = 1'b0;
    wb_id_d    = wb_id_q;
    wb_res_d   = wb_res_q;
    if (flush_i) begin
      credits_d = '0;
      cnt_d     = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      wb_valid_d = sel_fast || sel_head || sel_byp;
      unique case (1'b1)
        sel_fast: begin
          wb_id_d  = fast_trans_id_i;
          wb_res_d = fast_result_i;
        end
        sel_head: begin
          wb_id_d  = id_mem_q[rd_ptr_q];
          wb_res_d = res_mem_q[rd_ptr_q];
        end
        sel_byp: begin
          wb_id_d  = mul_trans_id_i;
          wb_res_d = mul_result_i;
        end
        default: ;
      endcase
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push) begin
        id_mem_d[wr_ptr_q]  = mul_trans_id_i;
        res_mem_d[wr_ptr_q] = mul_result_i;
        wr_ptr_d            = ptr_inc(wr_ptr_q);
      end
      cnt_d     = cnt_q + CW'(push) - CW'(pop);
      credits_d = credits_q + CW'(issue_ok) - CW'(pop || sel_byp);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits_q  <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_id_q    <= '0;
      wb_res_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        id_mem_q[i]  <= '0;
        res_mem_q[i] <= '0;
      end
    end else begin
      credits_q  <= credits_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_id_q    <= wb_id_d;
      wb_res_q   <= wb_res_d;
      id_mem_q   <= id_mem_d;
      res_mem_q  <= res_mem_d;
    end
  end

`ifdef FLU_WB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          fast_ready_q, fast_ready_d;
  logic          lost;

  assign lost         = fast_valid_i && !fifo_empty;
  assign fast_ready_o = fast_ready_q;

  // Count cycles the head loses to fast traffic; at the limit hold fast off once.
  always_comb begin
    starve_d     = '0;
    fast_ready_d = 1'b1;
    if (!flush_i && lost) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) begin
        fast_ready_d = 1'b0;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  // Starvation guard registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q     <= '0;
      fast_ready_q <= 1'b1;
    end else begin
      starve_q     <= starve_d;
      fast_ready_q <= fast_ready_d;
    end
  end
`else
  assign fast_ready_o = 1'b1;
`endif

  // Credits must keep the FIFO from ever overflowing.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !flush_i && cnt_q == CW'(DEPTH)));

endmodule

// File: tb/tb_flu_wb_scheduler.sv
// Self-checking bench for flu_wb_scheduler: directed cases plus a
// randomized run against a queue-based model of the writeback rules.
module tb_flu_wb_scheduler;

  localparam int DEPTH = 2;
  localparam int TIDW  = 3;
  localparam int XLEN  = 64;
  localparam int LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            fast_valid_i = 1'b0;
  logic [TIDW-1:0] fast_trans_id_i = '0;
  logic [XLEN-1:0] fast_result_i = '0;
  logic            fast_ready_o;
  logic            mul_issue_i = 1'b0;
  logic            mul_issue_ready_o;
  logic            mul_valid_i = 1'b0;
  logic [TIDW-1:0] mul_trans_id_i = '0;
  logic [XLEN-1:0] mul_result_i = '0;
  logic            wb_valid_o;
  logic [TIDW-1:0] wb_trans_id_o;
  logic [XLEN-1:0] wb_result_o;
  logic [$clog2(DEPTH+1)-1:0] occupancy_o;

  flu_wb_scheduler #(
    .DEPTH(DEPTH), .TRANS_ID_BITS(TIDW),
    .XLEN(XLEN), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .fast_valid_i(fast_valid_i),
    .fast_trans_id_i(fast_trans_id_i),
    .fast_result_i(fast_result_i),
    .fast_ready_o(fast_ready_o),
    .mul_issue_i(mul_issue_i),
    .mul_issue_ready_o(mul_issue_ready_o),
    .mul_valid_i(mul_valid_i),
    .mul_trans_id_i(mul_trans_id_i),
    .mul_result_i(mul_result_i),
    .wb_valid_o(wb_valid_o),
    .wb_trans_id_o(wb_trans_id_o),
    .wb_result_o(wb_result_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TIDW-1:0] id;
    logic [XLEN-1:0] res;
  } ent_t;

  ent_t            mq[$];
  int              m_credits = 0;
  int              m_starve  = 0;
  int              m_pend    = 0;
  logic            e_wbv = 1'b0;
  logic [TIDW-1:0] e_id  = '0;
  logic [XLEN-1:0] e_res = '0;
  logic            e_fr  = 1'b1;
  bit              chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_proto = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model(input logic fv, input logic [TIDW-1:0] fid,
                       input logic [XLEN-1:0] fres, input logic mi,
                       input logic mv, input logic [TIDW-1:0] mid,
                       input logic [XLEN-1:0] mres, input logic fl,
                       input logic rst);
    bit   inc, dec, lost;
    ent_t e, n;
    n.id  = mid;
    n.res = mres;
    if (rst) begin
      mq.delete();
      m_credits = 0; m_starve = 0; m_pend = 0;
      e_wbv = 1'b0; e_id = '0; e_res = '0; e_fr = 1'b1;
    end else if (fl) begin
      mq.delete();
      m_credits = 0; m_starve = 0; m_pend = 0;
      e_wbv = 1'b0; e_fr = 1'b1;
    end else begin
      if (mi && m_credits >= DEPTH) begin
        n_proto++;
        $display("[TB] protocol: mul_issue while not ready");
      end
      if (fv && !e_fr) begin
        n_proto++;
        $display("[TB] protocol: fast_valid while not ready");
      end
      inc = mi && (m_credits < DEPTH);
      dec = 1'b0;
      lost = 1'b0;
      e_wbv = 1'b1;
      if (fv) begin
        e_id = fid; e_res = fres;
        lost = (mq.size() != 0);
        if (mv) mq.push_back(n);
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        e_id = e.id; e_res = e.res; dec = 1'b1;
        if (mv) mq.push_back(n);
      end else if (mv) begin
        e_id = mid; e_res = mres; dec = 1'b1;
      end else begin
        e_wbv = 1'b0;
      end
      m_credits = m_credits + int'(inc) - int'(dec);
      if (mv) m_pend--;
      if (inc) m_pend++;
`ifdef FLU_WB_STARVE_GUARD_EN
      e_fr = 1'b1;
      if (lost) begin
        m_starve++;
        if (m_starve == LIMIT) begin
          e_fr = 1'b0;
          m_starve = 0;
        end
      end else begin
        m_starve = 0;
      end
`else
      e_fr = 1'b1;
`endif
    end
  endtask

  task automatic step(input logic fv, input logic [TIDW-1:0] fid,
                      input logic [XLEN-1:0] fres, input logic mi,
                      input logic mv, input logic [TIDW-1:0] mid,
                      input logic [XLEN-1:0] mres, input logic fl,
                      input logic rst);
    @(negedge clk);
    fast_valid_i = fv; fast_trans_id_i = fid; fast_result_i = fres;
    mul_issue_i = mi;
    mul_valid_i = mv; mul_trans_id_i = mid; mul_result_i = mres;
    flush_i = fl; rst_i = rst;
    model(fv, fid, fres, mi, mv, mid, mres, fl, rst);
    chk_en = 1'b1;
    @(posedge clk);
    #3;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue();
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  // Every cycle: DUT outputs against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        chk("wb_valid", 64'(wb_valid_o), 64'(e_wbv));
        chk("wb_trans_id", 64'(wb_trans_id_o), 64'(e_id));
        chk("wb_result", wb_result_o, e_res);
        chk("occupancy", 64'(occupancy_o), 64'(mq.size()));
        chk("mul_issue_ready", 64'(mul_issue_ready_o),
            64'(m_credits < DEPTH));
        chk("fast_ready", 64'(fast_ready_o), 64'(e_fr));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic            fv, mi, mv, fl, rs;
    logic [TIDW-1:0] fid, mid;
    logic [XLEN-1:0] fres, mres;
    int              r;

    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_wb_id", 64'(wb_trans_id_o), 64'd0);
    chk("rst_wb_res", wb_result_o, 64'd0);
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    chk("rst_ready", 64'(mul_issue_ready_o), 64'd1);
    chk("rst_fast_ready", 64'(fast_ready_o), 64'd1);

    // bypass
    issue();
    step(0, 0, 0, 0, 1, 3'd5, 64'hDEAD, 0, 0);
    chk("byp_valid", 64'(wb_valid_o), 64'd1);
    chk("byp_id", 64'(wb_trans_id_o), 64'd5);
    chk("byp_res", wb_result_o, 64'hDEAD);
    chk("byp_occ", 64'(occupancy_o), 64'd0);

    // collision
    issue();
    step(1, 3'd2, 64'h11, 0, 1, 3'd6, 64'h22, 0, 0);
    chk("col_id1", 64'(wb_trans_id_o), 64'd2);
    chk("col_res1", wb_result_o, 64'h11);
    chk("col_occ", 64'(occupancy_o), 64'd1);
    idle();
    chk("col_valid2", 64'(wb_valid_o), 64'd1);
    chk("col_id2", 64'(wb_trans_id_o), 64'd6);
    chk("col_res2", wb_result_o, 64'h22);
    chk("col_occ2", 64'(occupancy_o), 64'd0);

    // credits
    issue();
    chk("cr_ready1", 64'(mul_issue_ready_o), 64'd1);
    issue();
    chk("cr_ready2", 64'(mul_issue_ready_o), 64'd0);
    issue();
    chk("cr_ready3", 64'(mul_issue_ready_o), 64'd0);
    step(0, 0, 0, 0, 1, 3'd1, 64'h1, 0, 0);
    chk("cr_wb_id", 64'(wb_trans_id_o), 64'd1);
    chk("cr_ready4", 64'(mul_issue_ready_o), 64'd1);
    step(0, 0, 0, 0, 1, 3'd3, 64'h3, 0, 0);
    issue();
    issue();
    chk("cr_ready5", 64'(mul_issue_ready_o), 64'd0);
    step(0, 0, 0, 0, 1, 3'd4, 64'h4, 0, 0);
    step(0, 0, 0, 0, 1, 3'd4, 64'h4, 0, 0);

    // flush
    issue();
    issue();
    step(1, 3'd0, 64'h100, 0, 1, 3'd4, 64'h44, 0, 0);
    step(1, 3'd1, 64'h101, 0, 1, 3'd7, 64'h77, 0, 0);
    chk("fl_occ_pre", 64'(occupancy_o), 64'd2);
    step(1, 3'd3, 64'h333, 0, 0, 0, 0, 1, 0);
    chk("fl_occ", 64'(occupancy_o), 64'd0);
    chk("fl_ready", 64'(mul_issue_ready_o), 64'd1);
    chk("fl_valid", 64'(wb_valid_o), 64'd0);
    chk("fl_id_hold", 64'(wb_trans_id_o), 64'd1);

    // starvation
    issue();
    step(1, 3'd2, 64'h200, 0, 1, 3'd5, 64'h55, 0, 0);
    chk("st_occ", 64'(occupancy_o), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      step(1, TIDW'(i), 64'(i), 0, 0, 0, 0, 0, 0);
`ifdef FLU_WB_STARVE_GUARD_EN
      chk("st_fast_ready", 64'(fast_ready_o), 64'(i != 4));
`else
      chk("st_fast_ready", 64'(fast_ready_o), 64'd1);
`endif
    end
`ifndef FLU_WB_STARVE_GUARD_EN
    step(1, 3'd6, 64'h6, 0, 0, 0, 0, 0, 0);
    step(1, 3'd7, 64'h7, 0, 0, 0, 0, 0, 0);
    chk("st_no_drain", 64'(occupancy_o), 64'd1);
`endif
    idle();
    chk("st_drain_id", 64'(wb_trans_id_o), 64'd5);
    chk("st_drain_res", wb_result_o, 64'h55);
    chk("st_drain_occ", 64'(occupancy_o), 64'd0);
    chk("st_fr_back", 64'(fast_ready_o), 64'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r    = int'($urandom_range(0, 199));
      rs   = (r == 0);
      fl   = (r >= 1 && r <= 3);
      fv   = ($urandom_range(0, 99) < 55) &&
             (e_fr || $urandom_range(0, 9) == 0);
      mi   = ($urandom_range(0, 99) < 40) &&
             ((m_credits < DEPTH) || $urandom_range(0, 19) == 0);
      mv   = (m_pend > 0) && ($urandom_range(0, 99) < 45);
      fid  = TIDW'($urandom);
      mid  = TIDW'($urandom);
      fres = {$urandom, $urandom};
      mres = {$urandom, $urandom};
      step(fv, fid, fres, mi, mv, mid, mres, fl, rs);
    end

    $display("[TB] protocol events seen: %0d", n_proto);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flu_wb_scheduler.md
# flu_wb_scheduler

Writeback scheduler for the fixed-latency unit (FLU) result port of the execute stage. Single-cycle producers (ALU, branch, CSR buffer) and the multi-cycle multiplier/divider share one scoreboard write port. The block arbitrates between them and buffers displaced multiplier results in a small FIFO. It also hands issue-side credits to the multiplier so that a completion is never lost.

## Interface
Parameters:
- DEPTH, 2: multiplier result FIFO entries; also the maximum number of multiplier ops in flight (≥1).
- TRANS_ID_BITS, 3: scoreboard transaction-ID width.
- XLEN, 64: result width.
- STARVE_LIMIT, 4: cycles a buffered result may wait before the starvation guard fires (≥1, guard build only).

Ports:
- clk_i  in  1  clock; the block has one clock.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  pipeline flush.
- fast_valid_i  in  1  single-cycle result present this cycle.
- fast_trans_id_i  in  TRANS_ID_BITS  ID of the fast result.
- fast_result_i  in  XLEN  fast result.
- fast_ready_o  out  1  issue may present a fast op next cycle.
- mul_issue_i  in  1  multiplier op issued this cycle (consumes a credit).
- mul_issue_ready_o  out  1  credit available.
- mul_valid_i  in  1  multiplier completion; always accepted.
- mul_trans_id_i  in  TRANS_ID_BITS  ID of the multiplier result.
- mul_result_i  in  XLEN  multiplier result.
- wb_valid_o  out  1  registered writeback valid.
- wb_trans_id_o  out  TRANS_ID_BITS  registered writeback ID.
- wb_result_o  out  XLEN  registered writeback data.
- occupancy_o  out  $clog2(DEPTH+1)  FIFO entry count.

## Operation
- **Credit counter** `credits` has range 0..DEPTH and counts multiplier ops issued whose results have not been written back.
  - `mul_issue_ready_o = (credits < DEPTH)`.
  - It increments on `mul_issue_i & mul_issue_ready_o`.
  - It decrements when a multiplier result wins writeback, either from the FIFO head or by bypass.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - `mul_issue_i` while not ready is ignored; the bench flags it as a protocol error.
- **Writeback selection** each cycle uses strict priority:
  1. `fast_valid_i`.
  2. The FIFO head, when the FIFO is non-empty.
  3. A `mul_valid_i` bypass, only when the FIFO is empty.
- **Buffering:** a `mul_valid_i` that does not win writeback is pushed to the FIFO tail.
  - Pushing and popping the head in the same cycle is legal.
  - The credit scheme guarantees there is no push while the FIFO is full. Overflow is a design error, checked by an assertion.
- **FIFO structure:** circular, with read and write pointers modulo DEPTH. The count is kept separately so that full and empty are unambiguous.
- **`fast_valid_i` while `fast_ready_o` was 0:** still accepted with top priority. It is a protocol error flagged by the bench.
- **Flush:**
  - Clears the FIFO, `credits`, and the starvation counter.
  - Drops any `mul_valid_i` and `mul_issue_i` in the flush cycle.
  - Forces `wb_valid_o` to 0 in the next cycle.
  - `fast_valid_i` in the flush cycle is dropped.

## Timing
- **Reset values:**
  - `wb_valid_o = 0`, `wb_trans_id_o = 0`, `wb_result_o = 0`.
  - `occupancy_o = 0`, `mul_issue_ready_o = 1`, `fast_ready_o = 1`.
  - All internal state is cleared.
- **Latency:** the result selected in cycle N appears on the `wb_*` outputs in cycle N+1. The outputs hold for one cycle only. `wb_result_o` and `wb_trans_id_o` retain their last value when `wb_valid_o = 0`.
- **Output timing:**
  - `mul_issue_ready_o` and `occupancy_o` are combinational from registered state. They reflect updates from the following cycle onward.
  - `fast_ready_o` is registered.
- **Reset** has priority over flush. Reset mid-operation discards all buffered results.
- **Best-case multiplier-to-writeback latency:**
  - Bypass: 1 cycle.
  - Buffered: 1 cycle plus the number of cycles the head is blocked.

## Configuration
- **`FLU_WB_STARVE_GUARD_EN` defined:**
  - A starvation counter increments each cycle the FIFO is non-empty and its head loses to a fast result.
  - The counter resets when the head drains, on flush, or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, `fast_ready_o` is driven 0 for exactly the next cycle. This lets the head drain, and the counter then restarts.
- **Undefined:** `fast_ready_o` is tied to 1 and the counter is absent. A buffered result can then be delayed without bound by continuous fast traffic.

## Test plan
- Reset, then idle → all outputs at reset values. `mul_issue_ready_o = 1` with `credits = 0`.
- Bypass path:
  - Stimulus: issue one mul (ID 5), then in a later cycle `mul_valid_i` with `result = 0xDEAD` and FIFO empty, no fast op.
  - Response: next cycle `wb_valid_o = 1`, ID 5, `0xDEAD`; `credits` returns to 0.
- Collision:
  - Stimulus: fast ID 2 (`0x11`) and mul ID 6 (`0x22`) in the same cycle.
  - Response: writeback of ID 2 at N+1 and ID 6 at N+2; `occupancy_o` is 1 in cycle N+1.
- Credits with DEPTH = 2:
  - Stimulus: issue two mul ops back-to-back.
  - Response: `mul_issue_ready_o = 0`, and a third `mul_issue_i` is ignored. Once one result is written back, ready returns to 1.
- Flush:
  - Stimulus: two entries buffered, then `flush_i`.
  - Response: `occupancy_o = 0` and `mul_issue_ready_o = 1` next cycle; `wb_valid_o = 0` in the cycle after the flush.
- Starvation guard, with the macro defined and STARVE_LIMIT = 4:
  - Stimulus: one buffered entry plus continuous `fast_valid_i`.
  - Response: after 4 lost cycles `fast_ready_o = 0` for 1 cycle. With fast traffic honouring it, the head drains; without the macro, no drain occurs.
